// File: rtl/matrix_scan_scheduler.sv
// matrix_scan_scheduler
//   Sequences one matrix frame for output_module. It reads each word from the
//   frame buffer, holds it on data_out, and then issues one strobe per word:
//   new_image for (0,0), new_column for word 0 of every later column, and
//   next_data for the remaining words. The next word is paced on tx_finish.
//
//   Optional feature: define SCAN_DWELL_EN to hold each column for
//   DWELL_CYCLES extra cycles. The hold comes before every column advance
//   and before frame_done.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   enable                   level; frames may start and continue while high
//   frame_start              single-cycle frame request
//   extra_bit_cfg            sampled at frame accept, drives extra_bit
//   rd_en, rd_addr, rd_data  frame-buffer read port (1-cycle read latency)
//   data_out                 current word, one SPI_SIZE lane per channel
//   new_image, new_column,
//   next_data                one-cycle strobes to output_module
//   extra_bit                to output_module
//   tx_finish                output_module idle
//   busy, frame_done         frame status
//   col_idx                  current column
module matrix_scan_scheduler #(
   parameter int unsigned CHANNEL_NUMBER   = 3,
   parameter int unsigned SPI_SIZE         = 8,
   parameter int unsigned COLUMNS          = 16,
   parameter int unsigned WORDS_PER_COLUMN = 8,
   parameter int unsigned ADDR_WIDTH       = (COLUMNS * WORDS_PER_COLUMN > 1) ?
                                             $clog2(COLUMNS * WORDS_PER_COLUMN) : 1,
   parameter int unsigned DWELL_CYCLES     = 64,
   localparam int unsigned COL_W           = (COLUMNS > 1) ? $clog2(COLUMNS) : 1
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     enable,
   input  logic                                     frame_start,
   input  logic                                     extra_bit_cfg,
   output logic                                     rd_en,
   output logic [ADDR_WIDTH-1:0]                    rd_addr,
   input  logic [SPI_SIZE*CHANNEL_NUMBER-1:0]       rd_data,
   output logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0]  data_out,
   output logic                                     new_image,
   output logic                                     new_column,
   output logic                                     next_data,
   output logic                                     extra_bit,
   input  logic                                     tx_finish,
   output logic                                     busy,
   output logic                                     frame_done,
   output logic [COL_W-1:0]                         col_idx
);

   localparam int unsigned WORD_W = (WORDS_PER_COLUMN > 1) ? $clog2(WORDS_PER_COLUMN) : 1;
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLUMNS - 1);
   localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS_PER_COLUMN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_ACK,
      S_WAIT,
      S_DWELL
   } state_t;

   state_t state, state_n;

   logic [COL_W-1:0]                         col_n;
   logic [WORD_W-1:0]                        word, word_n;
   logic                                     rd_en_n;
   logic [ADDR_WIDTH-1:0]                    rd_addr_n;
   logic                                     rd_vld;
   logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0]  data_n;
   logic                                     new_image_n, new_column_n, next_data_n;
   logic                                     extra_bit_n, busy_n, frame_done_n;
   logic                                     pending, pending_n;
   logic                                     col_step;

`ifdef SCAN_DWELL_EN
   localparam int unsigned DWELL_CNT_W = 16;
   logic [DWELL_CNT_W-1:0] dwell_cnt, dwell_cnt_n;
`endif

   // Flat frame-buffer address of (column, word).
   function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [COL_W-1:0]  c,
                                                     input logic [WORD_W-1:0] w);
      return ADDR_WIDTH'(32'(c) * WORDS_PER_COLUMN + 32'(w));
   endfunction

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n      = state;
      col_n        = col_idx;
      word_n       = word;
      rd_en_n      = 1'b0;
      rd_addr_n    = rd_addr;
      data_n       = data_out;
      new_image_n  = 1'b0;
      new_column_n = 1'b0;
      next_data_n  = 1'b0;
      extra_bit_n  = extra_bit;
      busy_n       = busy;
      frame_done_n = 1'b0;
      pending_n    = pending | frame_start;
      col_step     = 1'b0;
`ifdef SCAN_DWELL_EN
      dwell_cnt_n  = dwell_cnt;
`endif

      case (state)
         // A request arriving with frame_done is held pending for one more cycle.
         S_IDLE: begin
            if (enable && (frame_start || pending) && !frame_done) begin
               col_n       = '0;
               word_n      = '0;
               extra_bit_n = extra_bit_cfg;
               busy_n      = 1'b1;
               pending_n   = 1'b0;
               rd_en_n     = 1'b1;
               rd_addr_n   = '0;
               state_n     = S_FETCH;
            end
         end
         // Stay here until the read data is actually on rd_data.
         S_FETCH: begin
            if (rd_vld) begin
               data_n  = rd_data;
               state_n = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (tx_finish) begin
               if (col_idx == '0 && word == '0) new_image_n  = 1'b1;
               else if (word == '0)             new_column_n = 1'b1;
               else                             next_data_n  = 1'b1;
               state_n = S_ACK;
            end
         end
         // tx_finish is still stale here: output_module has not left idle yet.
         S_ACK: state_n = S_WAIT;
         S_WAIT: begin
            if (tx_finish) begin
               if (!enable) begin
                  busy_n  = 1'b0;
                  state_n = S_IDLE;
               end else if (word != WORD_LAST) begin
                  word_n    = word + WORD_W'(1);
                  rd_en_n   = 1'b1;
                  rd_addr_n = addr_of(col_idx, word_n);
                  state_n   = S_FETCH;
               end else begin
`ifdef SCAN_DWELL_EN
                  dwell_cnt_n = '0;
                  state_n     = S_DWELL;
`else
                  col_step    = 1'b1;
`endif
               end
            end
         end
`ifdef SCAN_DWELL_EN
         S_DWELL: begin
            if (!enable) begin
               busy_n  = 1'b0;
               state_n = S_IDLE;
            end else if (32'(dwell_cnt) + 32'd1 >= DWELL_CYCLES) begin
               col_step = 1'b1;
            end else begin
               dwell_cnt_n = dwell_cnt + DWELL_CNT_W'(1);
            end
         end
`endif
         default: state_n = S_IDLE;
      endcase

      // Either advance to the next column or close the frame.
      if (col_step) begin
         if (col_idx != COL_LAST) begin
            col_n     = col_idx + COL_W'(1);
            word_n    = '0;
            rd_en_n   = 1'b1;
            rd_addr_n = addr_of(col_n, '0);
            state_n   = S_FETCH;
         end else begin
            frame_done_n = 1'b1;
            busy_n       = 1'b0;
            state_n      = S_IDLE;
         end
      end
   end

   // Registered datapath and outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_idx    <= '0;
         word       <= '0;
         rd_en      <= 1'b0;
         rd_addr    <= '0;
         rd_vld     <= 1'b0;
         data_out   <= '0;
         new_image  <= 1'b0;
         new_column <= 1'b0;
         next_data  <= 1'b0;
         extra_bit  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         pending    <= 1'b0;
      end else begin
         col_idx    <= col_n;
         word       <= word_n;
         rd_en      <= rd_en_n;
         rd_addr    <= rd_addr_n;
         rd_vld     <= rd_en;
         data_out   <= data_n;
         new_image  <= new_image_n;
         new_column <= new_column_n;
         next_data  <= next_data_n;
         extra_bit  <= extra_bit_n;
         busy       <= busy_n;
         frame_done <= frame_done_n;
         pending    <= pending_n;
      end
   end

`ifdef SCAN_DWELL_EN
   // Dwell counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) dwell_cnt <= '0;
      else     dwell_cnt <= dwell_cnt_n;
   end
`endif

endmodule
